// File: rtl/rom_fetch.sv
// PRG/CHR ROM read responder with one-word line buffer per port,
// arbitrated round-robin onto a single 32-bit external read bus.
module rom_fetch #(
  parameter int AW = 21,
  localparam int MW = AW - 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inval,
  input  logic [AW-1:0] chrbase,
  input  logic [AW-1:0] promaddr,
  input  logic          promreq,
  output logic          promack,
  output logic [7:0]    promdata,
  input  logic [AW-1:0] cromaddr,
  input  logic          cromreq,
  output logic          cromack,
  output logic [7:0]    cromdata,
  output logic [MW-1:0] memaddr,
  output logic          memreq,
  input  logic          memack,
  input  logic [31:0]   memrdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_e;

  state_e        state_q;
  logic          last_q;
  logic          gnt_q;
  logic [1:0]    lane_q;
  logic          kill_q;

  logic          pvld_q;
  logic [MW-1:0] ptag_q;
  logic [31:0]   pbuf_q;
  logic          cvld_q;
  logic [MW-1:0] ctag_q;
  logic [31:0]   cbuf_q;

  logic          pack_q;
  logic [7:0]    pdata_q;
  logic          cack_q;
  logic [7:0]    cdata_q;
  logic          mreq_q;
  logic [MW-1:0] maddr_q;

  logic [AW-1:0] caddr;
  logic [AW-1:0] gaddr;
  logic [MW-1:0] gword;
  logic [31:0]   gbuf;
  logic          ppend;
  logic          cpend;
  logic          gsel;
  logic          hit;
  logic          fill;

  assign promack  = pack_q;
  assign promdata = pdata_q;
  assign cromack  = cack_q;
  assign cromdata = cdata_q;
  assign memreq   = mreq_q;
  assign memaddr  = maddr_q;

  function automatic logic [7:0] lane_sel(
    input logic [31:0] w,
    input logic [1:0]  l
  );
    logic [7:0] b;
    unique case (l)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // gsel: 0 = PRG, 1 = CHR; on contention the port not served last wins
  always_comb begin
    caddr = cromaddr + chrbase;
    ppend = promreq & ~pack_q;
    cpend = cromreq & ~cack_q;
    gsel  = 1'b0;
    unique case (1'b1)
      (ppend & cpend):  gsel = ~last_q;
      (cpend & ~ppend): gsel = 1'b1;
      default:          gsel = 1'b0;
    endcase
    gaddr = gsel ? caddr : promaddr;
    gword = gaddr[AW-1:2];
    gbuf  = gsel ? cbuf_q : pbuf_q;
    hit   = gsel ? (cvld_q && ctag_q == gword)
                 : (pvld_q && ptag_q == gword);
    fill  = ~(inval | kill_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      lane_q  <= 2'd0;
      kill_q  <= 1'b0;
      pvld_q  <= 1'b0;
      ptag_q  <= '0;
      pbuf_q  <= '0;
      cvld_q  <= 1'b0;
      ctag_q  <= '0;
      cbuf_q  <= '0;
      pack_q  <= 1'b0;
      pdata_q <= '0;
      cack_q  <= 1'b0;
      cdata_q <= '0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      if (inval) begin
        pvld_q <= 1'b0;
        cvld_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (ppend | cpend) begin
            last_q <= gsel;
            gnt_q  <= gsel;
            lane_q <= gaddr[1:0];
            if (hit) begin
              state_q <= RESP;
              if (gsel) begin
                cack_q  <= 1'b1;
                cdata_q <= lane_sel(gbuf, gaddr[1:0]);
              end else begin
                pack_q  <= 1'b1;
                pdata_q <= lane_sel(gbuf, gaddr[1:0]);
              end
            end else begin
              state_q <= FETCH;
              mreq_q  <= 1'b1;
              maddr_q <= gword;
              kill_q  <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (inval) kill_q <= 1'b1;
          if (memack) begin
            mreq_q  <= 1'b0;
            state_q <= RESP;
            if (gnt_q) begin
              cack_q  <= 1'b1;
              cdata_q <= lane_sel(memrdata, lane_q);
              if (fill) begin
                cvld_q <= 1'b1;
                ctag_q <= maddr_q;
                cbuf_q <= memrdata;
              end
            end else begin
              pack_q  <= 1'b1;
              pdata_q <= lane_sel(memrdata, lane_q);
              if (fill) begin
                pvld_q <= 1'b1;
                ptag_q <= maddr_q;
                pbuf_q <= memrdata;
              end
            end
          end
        end
        RESP: begin
          pack_q  <= 1'b0;
          cack_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch: miss/hit, CHR wrap, contention,
// round-robin, invalidate during fetch, async reset mid-fetch.
module tb_rom_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inval = 1'b0;
  logic [20:0] chrbase = '0;
  logic [20:0] promaddr = '0;
  logic        promreq = 1'b0;
  logic        promack;
  logic [7:0]  promdata;
  logic [20:0] cromaddr = '0;
  logic        cromreq = 1'b0;
  logic        cromack;
  logic [7:0]  cromdata;
  logic [18:0] memaddr;
  logic        memreq;
  logic        memack = 1'b0;
  logic [31:0] memrdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rom_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .inval    (inval),
    .chrbase  (chrbase),
    .promaddr (promaddr),
    .promreq  (promreq),
    .promack  (promack),
    .promdata (promdata),
    .cromaddr (cromaddr),
    .cromreq  (cromreq),
    .cromack  (cromack),
    .cromdata (cromdata),
    .memaddr  (memaddr),
    .memreq   (memreq),
    .memack   (memack),
    .memrdata (memrdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic p_hit(
    input logic [20:0] a,
    input logic [7:0]  d
  );
    promaddr = a;
    step();
    chk("hit_gap_ack", 32'(promack), 32'h0);
    step();
    chk("hit_ack", 32'(promack), 32'h1);
    chk("hit_data", 32'(promdata), 32'(d));
    chk("hit_nomem", 32'(memreq), 32'h0);
  endtask

  initial begin
    #2;
    chk("rst_pack", 32'(promack), 32'h0);
    chk("rst_cack", 32'(cromack), 32'h0);
    chk("rst_mreq", 32'(memreq), 32'h0);
    chk("rst_pdata", 32'(promdata), 32'h0);
    chk("rst_cdata", 32'(cromdata), 32'h0);
    chk("rst_maddr", 32'(memaddr), 32'h0);
    step();
    step();
    reset = 1'b1;

    // PRG miss then sequential hits
    promaddr = 21'h00004;
    promreq  = 1'b1;
    step();
    chk("miss_mreq", 32'(memreq), 32'h1);
    chk("miss_maddr", 32'(memaddr), 32'h1);
    chk("miss_noack", 32'(promack), 32'h0);
    step();
    chk("miss_hold1", 32'(memreq), 32'h1);
    step();
    chk("miss_hold2", 32'(memreq), 32'h1);
    memack   = 1'b1;
    memrdata = 32'hDDCCBBAA;
    step();
    memack   = 1'b0;
    memrdata = 32'h0;
    chk("fill_ack", 32'(promack), 32'h1);
    chk("fill_data", 32'(promdata), 32'hAA);
    chk("fill_mreq", 32'(memreq), 32'h0);
    p_hit(21'h00005, 8'hBB);
    p_hit(21'h00006, 8'hCC);
    p_hit(21'h00007, 8'hDD);
    promreq = 1'b0;
    step();
    chk("p_drop_ack", 32'(promack), 32'h0);

    // stray memack while idle
    memack   = 1'b1;
    memrdata = 32'hFFFFFFFF;
    step();
    memack = 1'b0;
    chk("stray_mreq", 32'(memreq), 32'h0);
    chk("stray_pack", 32'(promack), 32'h0);
    chk("stray_cack", 32'(cromack), 32'h0);

    // CHR offset with 21-bit wrap
    chrbase  = 21'h1FFFFE;
    cromaddr = 21'h00003;
    cromreq  = 1'b1;
    step();
    chk("wrap_mreq", 32'(memreq), 32'h1);
    chk("wrap_maddr", 32'(memaddr), 32'h0);
    memack   = 1'b1;
    memrdata = 32'h44332211;
    step();
    memack = 1'b0;
    chk("wrap_ack", 32'(cromack), 32'h1);
    chk("wrap_data", 32'(cromdata), 32'h22);
    chk("wrap_mdrop", 32'(memreq), 32'h0);
    cromaddr = 21'h00002;
    step();
    chk("wrap_gap", 32'(cromack), 32'h0);
    step();
    chk("chit_ack", 32'(cromack), 32'h1);
    chk("chit_data", 32'(cromdata), 32'h11);
    chk("chit_nomem", 32'(memreq), 32'h0);
    cromreq = 1'b0;
    step();

    // contention from reset: PRG first
    reset = 1'b0;
    #1;
    chrbase  = '0;
    promaddr = 21'h00100;
    cromaddr = 21'h00010;
    promreq  = 1'b1;
    cromreq  = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("ct1_mreq", 32'(memreq), 32'h1);
    chk("ct1_maddr", 32'(memaddr), 32'h40);
    chk("ct1_cack", 32'(cromack), 32'h0);
    memack   = 1'b1;
    memrdata = 32'h000000A5;
    step();
    memack  = 1'b0;
    promreq = 1'b0;
    chk("ct1_ack", 32'(promack), 32'h1);
    chk("ct1_data", 32'(promdata), 32'hA5);
    chk("ct1_mdrop", 32'(memreq), 32'h0);
    step();
    chk("ct_one_out", 32'(memreq), 32'h0);
    chk("ct_resp_cack", 32'(cromack), 32'h0);
    step();
    chk("ct2_mreq", 32'(memreq), 32'h1);
    chk("ct2_maddr", 32'(memaddr), 32'h4);
    memack   = 1'b1;
    memrdata = 32'h0000005A;
    step();
    memack = 1'b0;
    chk("ct2_ack", 32'(cromack), 32'h1);
    chk("ct2_data", 32'(cromdata), 32'h5A);

    // round-robin with both ports hitting
    promreq = 1'b1;
    cromreq = 1'b1;
    step();
    chk("rr_idle_p", 32'(promack), 32'h0);
    chk("rr_idle_c", 32'(cromack), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_pack", 32'(promack), 32'((i % 2) == 0));
      chk("rr_cack", 32'(cromack), 32'((i % 2) == 1));
      chk("rr_nomem", 32'(memreq), 32'h0);
      step();
    end
    promreq = 1'b0;
    cromreq = 1'b0;
    chk("rr_pdata", 32'(promdata), 32'hA5);
    chk("rr_cdata", 32'(cromdata), 32'h5A);

    // invalidate while fetching
    promaddr = 21'h00200;
    promreq  = 1'b1;
    step();
    chk("iv_mreq", 32'(memreq), 32'h1);
    chk("iv_maddr", 32'(memaddr), 32'h80);
    inval = 1'b1;
    step();
    inval = 1'b0;
    chk("iv_hold", 32'(memreq), 32'h1);
    memack   = 1'b1;
    memrdata = 32'h11223344;
    step();
    memack = 1'b0;
    chk("iv_ack", 32'(promack), 32'h1);
    chk("iv_data", 32'(promdata), 32'h44);
    step();
    chk("iv_gap", 32'(memreq), 32'h0);
    step();
    chk("iv_refetch", 32'(memreq), 32'h1);
    chk("iv_remaddr", 32'(memaddr), 32'h80);
    memack   = 1'b1;
    memrdata = 32'h11223355;
    step();
    memack  = 1'b0;
    promreq = 1'b0;
    chk("iv_reack", 32'(promack), 32'h1);
    chk("iv_redata", 32'(promdata), 32'h55);
    step();
    cromreq = 1'b1;
    step();
    chk("iv_cmiss", 32'(memreq), 32'h1);
    chk("iv_cmaddr", 32'(memaddr), 32'h4);
    memack   = 1'b1;
    memrdata = 32'h00000077;
    step();
    memack  = 1'b0;
    cromreq = 1'b0;
    chk("iv_cdata", 32'(cromdata), 32'h77);
    step();

    // async reset in the middle of a fetch
    promaddr = 21'h00300;
    promreq  = 1'b1;
    step();
    chk("ar_mreq", 32'(memreq), 32'h1);
    chk("ar_maddr", 32'(memaddr), 32'hC0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_mreq0", 32'(memreq), 32'h0);
    chk("ar_pack0", 32'(promack), 32'h0);
    chk("ar_pdata0", 32'(promdata), 32'h0);
    chk("ar_cdata0", 32'(cromdata), 32'h0);
    chk("ar_maddr0", 32'(memaddr), 32'h0);
    promreq = 1'b0;
    step();
    reset    = 1'b1;
    promaddr = 21'h00200;
    promreq  = 1'b1;
    step();
    chk("ar_miss", 32'(memreq), 32'h1);
    chk("ar_mmaddr", 32'(memaddr), 32'h80);
    memack   = 1'b1;
    memrdata = 32'h000000FF;
    step();
    memack  = 1'b0;
    promreq = 1'b0;
    chk("ar_ack", 32'(promack), 32'h1);
    chk("ar_data", 32'(promdata), 32'hFF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
- Responder end of the mapper ROM read handshake. Serves the PRG ROM request port (promaddr/promreq/promack/promdata) and the CHR ROM request port (cromaddr/cromreq/cromack/cromdata) that every mapper drives.
- Arbitrates both ports onto one 32-bit word-wide external memory read bus that holds the cartridge image.
- Keeps a one-word line buffer per port so sequential byte fetches hit without a memory access.
- Sits between the mapper instance and the external memory controller.

Parameters:
- AW, 21, byte address width of both ROM ports.
- MW, 19, word address width of external bus; fixed at AW-2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- inval  input  1  one-cycle pulse: invalidate both line buffers (new image loaded).
- chrbase  input  21  byte offset of CHR ROM within the image; quasi-static.
- promaddr  input  21  PRG byte address; stable while promreq high.
- promreq  input  1  PRG read request.
- promack  output  1  one-cycle pulse: promdata valid.
- promdata  output  8  PRG read data; held until next promack.
- cromaddr  input  21  CHR byte address, image-relative after adding chrbase.
- cromreq  input  1  CHR read request.
- cromack  output  1  one-cycle pulse: cromdata valid.
- cromdata  output  8  CHR read data; held until next cromack.
- memaddr  output  19  external word address.
- memreq  output  1  external read request; held until memack.
- memack  input  1  one-cycle pulse: memrdata valid.
- memrdata  input  32  external read word, little-endian bytes.

Behaviour:
- Reset (reset low, async):
  - promack, cromack, memreq = 0.
  - promdata, cromdata = 0; memaddr = 0.
  - Both buffers invalid; arbiter last-grant = CHR; FSM = IDLE.
- Effective addresses:
  - PRG byte address = promaddr.
  - CHR byte address = (cromaddr + chrbase) mod 2^21; 21-bit wrap, carry discarded.
  - Word address = byte address [20:2]; byte lane = byte address [1:0]; lane 0 = memrdata[7:0], lane 3 = memrdata[31:24].
- Handshake: a port is pending when its req is high and its ack is not being asserted this cycle. The requester drops req or presents a new address in the cycle after ack; req high in that cycle starts a new request.
- Arbitration, in IDLE only:
  - One pending port is granted.
  - Both pending: grant the port not granted last (round-robin). Last-grant updates on every grant.
- FSM:
  - IDLE -> granted port hits (buffer valid and tag == word address): RESP. That port's ack pulses and data is driven the next cycle. Hit latency: req sampled at cycle N, ack at N+1.
  - IDLE -> granted port misses: FETCH. memaddr = word address and memreq = 1 from the next cycle.
  - FETCH -> on memack: memreq drops the same edge; the port's buffer is loaded with memrdata and the tag; RESP. Ack and data appear the cycle after memack.
  - RESP -> IDLE after one cycle; ack is exactly one cycle wide.
  - No new grant occurs in the RESP cycle, so back-to-back hits from one port complete every 2 cycles.
- Invalidate:
  - inval in IDLE or RESP: both buffers become invalid next edge.
  - inval during FETCH: the pending fetch completes and its data is delivered, but the buffer is left invalid (invalidate wins over fill in the same or any earlier FETCH cycle).
- Boundaries:
  - memack while memreq is low is ignored.
  - memrdata is sampled only in the memack cycle.
  - A req that drops before its grant is never served.
  - A req that drops after its grant is still completed and acked; the requester ignores that ack.
  - The CHR port's wrapped address may alias the PRG buffer word; the buffers are independent and are not shared.
  - chrbase changes take effect on the next grant and do not flush buffers; software must pulse inval.

Test Plan:
- PRG miss then hits: promaddr=0x00004, memack 3 cycles after memreq, memrdata=0xDDCCBBAA -> memaddr=0x00001, promdata=0xAA one cycle after memack; then promaddr 0x00005/6/7 -> 0xBB/0xCC/0xDD, each acked 1 cycle after req, memreq stays low.
- CHR offset and wrap: chrbase=0x1FFFFE, cromaddr=0x00003 -> memaddr=0x00000, lane 1 selected; cromdata=memrdata[15:8].
- Contention: promreq and cromreq both pending from reset, both miss -> CHR-last reset state grants PRG first, then CHR; exactly one memreq outstanding at a time.
- Round-robin fairness: both ports continuously requesting hit addresses -> acks alternate PRG, CHR, PRG, CHR.
- Invalidate during fetch: inval pulse while memreq high -> data delivered with ack; an immediate re-request of the same word issues a new memreq.
- Async reset mid-FETCH: reset low while memreq high -> memreq, acks and data go to 0 immediately; after release, a first request to the old word misses.
